fifo_stream_reader: RTL

- Downstream consumer of sync_fifo's read port.
- Converts the FIFO's registered read (rd_en → rdata one cycle later) into a valid/ready streaming master with first-word-fall-through semantics.
- Holds a 2-entry output skid buffer so it sustains 1 word/cycle under continuous m_ready.
- Never issues a read against an empty FIFO, so sync_fifo rd_error never fires.
- Provides a flush and a transfer counter for the datapath control block.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/skid_buffer2.sv | 69 ++++++
 rtl/fifo_stream_reader.sv | 63 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Constants and word type shared between sync_fifo and its stream reader.
package fifo_pkg;

    localparam int unsigned FifoWidth = 8;
    localparam int unsigned FifoDepth = 16;

    typedef logic [FifoWidth-1:0] word_t;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry in-order holding buffer: head is always the oldest word, tail the second.
module skid_buffer2
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FifoWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; with a single entry the new word goes straight to head.
                if (occ_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
        if (flush) begin
            occ_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = head_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns sync_fifo's registered read port into a first-word-fall-through valid/ready stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FifoWidth,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rdata,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    logic [1:0]           occupancy;
    logic                 inflight_q;
    logic                 pop;
    logic                 push;
    logic [2:0]           credits_used;
    logic [CNT_WIDTH-1:0] xfer_count_q;

    always_comb begin
        pop          = m_valid && m_ready;
        // Slots already claimed next cycle: held words plus the word on the bus, minus this pop.
        credits_used = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en   = !fifo_empty && !flush && !reset && (credits_used < 3'd2);
        push         = inflight_q && !flush;
        m_valid      = (occupancy != 2'd0);
    end

    skid_buffer2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (m_data),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop) begin
                xfer_count_q <= xfer_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign xfer_count = xfer_count_q;

endmodule
